// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matrix-vector sequencing controller.
package matmul_pkg;

    localparam int DEPTH_DEF      = 8;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_W_DEF     = 16;
    localparam int WORD_W_DEF     = DEPTH_DEF * DATA_WIDTH_DEF;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Word-wide memory read port: read/waitrequest request side, readdatavalid return side.
interface matmul_seq_ctrl_if
    import matmul_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_waitrequest;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_rdvalid;

    modport master (
        output mem_rd, mem_addr,
        input  mem_waitrequest, mem_rdata, mem_rdvalid
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_waitrequest, mem_rdata, mem_rdvalid
    );
endinterface

// File: rtl/matmul_fetch.sv
// Issues DEPTH+1 consecutive word reads and captures the in-order returns into a local buffer.
module matmul_fetch
    import matmul_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load,
    input  logic [ADDR_W-1:0]                           base_addr,
    input  logic                                        active,
    matmul_seq_ctrl_if.master                           mem,
    output logic [DEPTH:0][DEPTH-1:0][DATA_WIDTH-1:0]   buf_q,
    output logic                                        finished
);
    localparam int            CW      = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] N_RD    = CW'(DEPTH + 1);
    localparam logic [CW-1:0] LAST_RD = CW'(DEPTH);

    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     iss_cnt;
    logic [CW-1:0]     ret_cnt;
    logic              issue;
    logic              ret;

    // Address is a pure function of registered state, so it holds while stalled.
    assign mem.mem_rd   = active && (iss_cnt != N_RD);
    assign mem.mem_addr = mem.mem_rd ? base_q + ADDR_W'(iss_cnt) : '0;
    assign issue        = mem.mem_rd && !mem.mem_waitrequest;
    assign ret          = active && mem.mem_rdvalid && (ret_cnt != N_RD);
    // Signalled on the last return so the buffer is complete at the next edge.
    assign finished     = ret && (ret_cnt == LAST_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else if (load) begin
            base_q  <= base_addr;
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (issue) iss_cnt <= iss_cnt + 1'b1;
            if (ret)   ret_cnt <= ret_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ret) begin
            for (int i = 0; i <= DEPTH; i++) begin
                if (ret_cnt == CW'(i)) buf_q[i] <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matrix-vector datapath: fetch, fill FIFOs column by column,
// run FIFOs/MACs for DEPTH products, drain the read latency, pulse done.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_LAT     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    output logic                        busy,
    output logic                        done,
    matmul_seq_ctrl_if.master           mem,
    output logic                        clear,
    output logic [DEPTH-1:0]            a_wren,
    output logic [DEPTH*DATA_WIDTH-1:0] a_wdata,
    output logic                        b_wren,
    output logic [DATA_WIDTH-1:0]       b_wdata,
    output logic                        fifo_rden,
    output logic                        mac_en
);
    localparam int            SW         = $clog2(DEPTH + RD_LAT + 1);
    localparam int            KW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SW-1:0] COL_LAST   = SW'(DEPTH - 1);
    localparam logic [SW-1:0] DRAIN_LAST = SW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] step;
    logic [KW-1:0] k;
    logic          fetch_done;

    logic [DEPTH:0][DEPTH-1:0][DATA_WIDTH-1:0] buf_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]          a_col;

    matmul_fetch #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .load      (state == IDLE && start),
        .base_addr (base_addr),
        .active    (state == FETCH),
        .mem       (mem),
        .buf_q     (buf_q),
        .finished  (fetch_done)
    );

    // step counts cycles within FILL/RUN/DRAIN and restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nx;
            step  <= (state_nx != state) ? '0 : step + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)              state_nx = CLEAR;
            CLEAR:                           state_nx = FETCH;
            FETCH:   if (fetch_done)         state_nx = FILL;
            FILL:    if (step == COL_LAST)   state_nx = RUN;
            RUN:     if (step == COL_LAST)   state_nx = (RD_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (step == DRAIN_LAST) state_nx = DONE;
            DONE:                            state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    assign k = step[KW-1:0];

    always_comb begin
        busy      = (state != IDLE);
        clear     = (state == CLEAR);
        done      = (state == DONE);
        fifo_rden = (state == RUN);
        b_wren    = (state == FILL);
        a_wren    = {DEPTH{state == FILL}};
        a_col     = '0;
        b_wdata   = '0;
        if (state == FILL) begin
            for (int r = 0; r < DEPTH; r++) a_col[r] = buf_q[r][k];
            b_wdata = buf_q[DEPTH][k];
        end
    end

    assign a_wdata = a_col;

    // mac_en is fifo_rden delayed by the FIFO read latency.
    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign mac_en = fifo_rden;
        end else begin : g_dly
            logic [RD_LAT-1:0] vld_pipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vld_pipe <= '0;
                else     vld_pipe <= RD_LAT'({vld_pipe, fifo_rden});
            end
            assign mac_en = vld_pipe[RD_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench: jobs push expected reads/FIFO columns/results; a negedge monitor
// models the FIFOs and MACs from DUT outputs and compares against A*b.
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    localparam int DEPTH    = DEPTH_DEF;
    localparam int DW       = DATA_WIDTH_DEF;
    localparam int AW       = 16;
    localparam int WW       = DEPTH * DW;
    localparam int RD_LAT   = 1;
    localparam int MEM_LAT  = 1;
    localparam int BASE_LAT = 1 + (DEPTH + 1 + MEM_LAT) + DEPTH + DEPTH + 1;

    typedef struct packed {
        logic [DEPTH-1:0][31:0] c;
        logic [AW-1:0]          base;
    } job_t;

    logic clk = 0;
    logic rst = 1;
    logic start = 0;
    logic [AW-1:0] base_addr = '0;
    logic busy, done, clear, b_wren, fifo_rden, mac_en;
    logic [DEPTH-1:0] a_wren;
    logic [WW-1:0]    a_wdata;
    logic [DW-1:0]    b_wdata;

    matmul_seq_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) mif();

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem(mif), .clear(clear),
        .a_wren(a_wren), .a_wdata(a_wdata), .b_wren(b_wren), .b_wdata(b_wdata),
        .fifo_rden(fifo_rden), .mac_en(mac_en)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int st_cyc = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    bit rand_wait = 0;

    job_t               job_q[$];
    logic [AW-1:0]      addr_q[$];
    logic [WW+DW-1:0]   fill_q[$];
    logic [WW+DW-1:0]   col_q[$];
    logic [WW-1:0]      mem_img [logic [AW-1:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Two builds with the other read latencies share the same memory responses;
    // their fetch behaviour does not depend on RD_LAT.
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_x
            localparam int LAT = (g == 0) ? 0 : 3;
            logic x_busy, x_done, x_clear, x_b_wren, x_rden, x_mac_en;
            logic [DEPTH-1:0] x_a_wren;
            logic [WW-1:0]    x_a_wdata;
            logic [DW-1:0]    x_b_wdata;
            int mcnt = 0;
            matmul_seq_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) xif();
            assign xif.mem_waitrequest = mif.mem_waitrequest;
            assign xif.mem_rdata       = mif.mem_rdata;
            assign xif.mem_rdvalid     = mif.mem_rdvalid;
            matmul_seq_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_W(AW), .RD_LAT(LAT)) u_x (
                .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
                .busy(x_busy), .done(x_done), .mem(xif), .clear(x_clear),
                .a_wren(x_a_wren), .a_wdata(x_a_wdata), .b_wren(x_b_wren), .b_wdata(x_b_wdata),
                .fifo_rden(x_rden), .mac_en(x_mac_en)
            );
            always @(negedge clk) begin
                if (rst) mcnt = 0;
                else begin
                    if (x_clear) mcnt = 0;
                    if (x_mac_en) mcnt++;
                    if (x_done) begin
                        chk($sformatf("x%0d_mac_cnt", LAT), mcnt, DEPTH);
                        chk($sformatf("x%0d_latency", LAT), cyc - st_cyc, BASE_LAT + LAT + stall_cnt);
                    end
                end
            end
        end
    endgenerate

    // Memory: fixed one-cycle latency, optional stall on one address or random stalls.
    initial begin : mem_model
        logic acc_r;
        logic [AW-1:0] acc_a;
        logic w;
        mif.mem_waitrequest = 0;
        mif.mem_rdvalid     = 0;
        mif.mem_rdata       = '0;
        forever begin
            @(negedge clk);
            acc_r = !rst && mif.mem_rd && !mif.mem_waitrequest;
            acc_a = mif.mem_addr;
            if (!rst && mif.mem_rd && mif.mem_waitrequest) stall_cnt++;
            @(posedge clk);
            #1;
            mif.mem_rdvalid = acc_r;
            if (acc_r) mif.mem_rdata = mem_img.exists(acc_a) ? mem_img[acc_a] : '0;
            else       mif.mem_rdata = WW'({$urandom, $urandom});
            w = 0;
            if (mif.mem_rd) begin
                if (stall_left > 0 && mif.mem_addr == stall_addr) begin
                    w = 1;
                    stall_left--;
                end else if (rand_wait && $urandom_range(0, 3) == 0) begin
                    w = 1;
                end
            end
            mif.mem_waitrequest = w;
        end
    end

    // Monitor: reads, FIFO writes, behavioural FIFO+MAC array, job completion.
    initial begin : monitor
        bit prev_stall = 0;
        bit prev_done = 0;
        logic [AW-1:0] prev_addr = '0;
        int acc [DEPTH];
        int mac_cnt = 0;
        int clear_cnt = 0;
        logic [WW+DW-1:0] e;
        job_t j;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_done = 0; mac_cnt = 0; clear_cnt = 0;
                col_q.delete();
                for (int r = 0; r < DEPTH; r++) acc[r] = 0;
            end else begin
                if (prev_stall) begin
                    chk("rd_hold", mif.mem_rd, 1);
                    chk("addr_hold", mif.mem_addr, prev_addr);
                end
                if (mif.mem_rd && !mif.mem_waitrequest) begin
                    if (addr_q.size() == 0) chk("unexpected_read", mif.mem_addr, 64'hDEAD_0000);
                    else chk("rd_addr", mif.mem_addr, addr_q.pop_front());
                end
                prev_stall = mif.mem_rd && mif.mem_waitrequest;
                prev_addr  = mif.mem_addr;

                if (prev_done) chk("busy_after_done", busy, 0);
                prev_done = done;

                if (clear) begin
                    clear_cnt++;
                    mac_cnt = 0;
                    col_q.delete();
                    for (int r = 0; r < DEPTH; r++) acc[r] = 0;
                end
                if (a_wren != '0 || b_wren) begin
                    chk("a_wren", a_wren, {DEPTH{1'b1}});
                    chk("b_wren", b_wren, 1);
                    if (fill_q.size() == 0) chk("unexpected_fill", a_wren, 0);
                    else begin
                        e = fill_q.pop_front();
                        chk("fill_a", a_wdata, e[WW+DW-1:DW]);
                        chk("fill_b", b_wdata, e[DW-1:0]);
                    end
                    col_q.push_back({a_wdata, b_wdata});
                end
                if (mac_en) begin
                    mac_cnt++;
                    if (col_q.size() == 0) chk("mac_underflow", mac_cnt, 0);
                    else begin
                        e = col_q.pop_front();
                        for (int r = 0; r < DEPTH; r++)
                            acc[r] += int'(e[DW + r*DW +: DW]) * int'(e[DW-1:0]);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (job_q.size() == 0) chk("unexpected_done", done, 0);
                    else begin
                        j = job_q.pop_front();
                        chk("latency", cyc - st_cyc, BASE_LAT + RD_LAT + stall_cnt);
                        chk("mac_cnt", mac_cnt, DEPTH);
                        chk("clear_cnt", clear_cnt, 1);
                        chk("reads_left", addr_q.size(), 0);
                        for (int r = 0; r < DEPTH; r++) chk($sformatf("c_row%0d", r), acc[r], j.c[r]);
                    end
                    clear_cnt = 0;
                end
            end
        end
    end

    // mode 1: A=identity, b=1..DEPTH; mode 2: A=all 2s, b=all 3s; else random.
    task automatic run_job(input logic [AW-1:0] base, input int mode);
        logic [DEPTH-1:0][DW-1:0] w [DEPTH+1];
        logic [WW+DW-1:0] e;
        job_t j;
        int s;
        for (int i = 0; i <= DEPTH; i++)
            for (int k = 0; k < DEPTH; k++)
                case (mode)
                    1:       w[i][k] = (i == DEPTH) ? DW'(k + 1) : ((i == k) ? DW'(1) : DW'(0));
                    2:       w[i][k] = (i == DEPTH) ? DW'(3) : DW'(2);
                    default: w[i][k] = DW'($urandom);
                endcase
        j.base = base;
        for (int r = 0; r < DEPTH; r++) begin
            s = 0;
            for (int k = 0; k < DEPTH; k++) s += int'(w[r][k]) * int'(w[DEPTH][k]);
            j.c[r] = 32'(s);
        end
        job_q.push_back(j);
        for (int i = 0; i <= DEPTH; i++) begin
            mem_img[AW'(base + i)] = w[i];
            addr_q.push_back(AW'(base + i));
        end
        for (int k = 0; k < DEPTH; k++) begin
            for (int r = 0; r < DEPTH; r++) e[DW + r*DW +: DW] = w[r][k];
            e[DW-1:0] = w[DEPTH][k];
            fill_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1; base_addr = base; st_cyc = cyc; stall_cnt = 0;
        @(posedge clk); #1;
        start = 0; base_addr = AW'($urandom);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt, target);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ctl"}, {busy, done, mif.mem_rd, clear, a_wren, b_wren, fifo_rden, mac_en,
                           g_x[0].x_mac_en, g_x[1].x_mac_en, g_x[1].x_busy}, 0);
        chk({nm, "_awdata"}, a_wdata, 0);
        chk({nm, "_addr_bw"}, {mif.mem_addr, b_wdata}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);

        // identity matrix, zero wait states
        run_job(16'h0100, 1);
        wait_done(1);

        // stall the fourth read for three cycles
        stall_addr = 16'h2003; stall_left = 3;
        run_job(16'h2000, 0);
        wait_done(2);
        chk("stall_consumed", stall_left, 0);

        // start pulse during RUN must be ignored
        run_job(16'h3000, 0);
        while (cyc < st_cyc + 22) begin @(posedge clk); #1; end
        start = 1; base_addr = 16'h5555;
        @(posedge clk); #1;
        start = 0;
        wait_done(3);
        repeat (10) @(posedge clk);
        chk("single_done", done_cnt, 3);

        // reset in the middle of FILL, then a clean restart
        run_job(16'h4000, 0);
        while (cyc < st_cyc + 14) begin @(posedge clk); #1; end
        rst = 1;
        job_q.delete(); fill_q.delete(); addr_q.delete();
        @(negedge clk);
        chk_idle_outputs("midrst");
        @(posedge clk); #1;
        rst = 0;
        run_job(16'h4000, 2);
        wait_done(4);

        // address wrap past the top of the address space
        run_job(16'hFFF8, 0);
        wait_done(5);

        // random data, random bases, random wait states
        rand_wait = 1;
        for (int i = 0; i < 4; i++) begin
            run_job(AW'($urandom), 0);
            wait_done(6 + i);
        end
        rand_wait = 0;

        chk("jobs_left", job_q.size(), 0);
        chk("fill_left", fill_q.size(), 0);
        chk("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
